sa_os_sequencer: RTL and testbench

Tile sequencer for the output-stationary HPE×VPE systolic array. It accepts one A vector and one B vector per handshake and drives them into the array with per-lane skew. It clears the array's accumulators between tiles, counts the K-length reduction and waits out the pipeline drain. It then raises a held result-valid so downstream logic can capture the array's Y bus.

---
 rtl/sa_seq_pkg.sv | 10 +
 rtl/sa_skew_line.sv | 22 ++
 rtl/sa_os_sequencer.sv | 104 ++++++++++
 tb/tb_sa_os_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_seq_pkg.sv
// sa_seq_pkg: state encoding, drain length and lane slicing shared by the tile sequencer
package sa_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, RESULT} seq_state_t;
  function automatic int drain_len(input int hpe, input int vpe, input int pe_lat);
    return hpe + vpe - 2 + pe_lat;
  endfunction
  function automatic int lane_lo(input int z, input int width);
    return z * width;
  endfunction
endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: DEPTH-stage lane delay line with synchronous flush
module sa_skew_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;
  // shift one stage per cycle; flush and reset empty the whole line
  always_ff @(posedge CLK or negedge RST)
    if (!RST) sr <= '0;
    else if (flush) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sa_os_sequencer.sv
// sa_os_sequencer: skewed tile feeder for the output-stationary array; SA_SEQ_PERF_EN adds perf counters
module sa_os_sequencer
  import sa_seq_pkg::*;
#(
  parameter int HPE    = 64,
  parameter int VPE    = 64,
  parameter int WIDTH  = 32,
  parameter int KW     = 16,
  parameter int PE_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*HPE-1:0] a_vec,
  input  logic [WIDTH*HPE-1:0] b_vec,
  output logic [WIDTH*HPE-1:0] AA,
  output logic [WIDTH*HPE-1:0] BB,
  output logic                 sa_rst_n,
  output logic                 busy,
  output logic                 res_valid,
`ifdef SA_SEQ_PERF_EN
  input  logic                 res_ready,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stalls
`else
  input  logic                 res_ready
`endif
);
  localparam int D  = drain_len(HPE, VPE, PE_LAT);
  localparam int DW = $clog2(D + 1);
  seq_state_t state;
  logic [KW-1:0] rem;
  logic [DW-1:0] dcnt;
  logic xfer, flush;
  logic [WIDTH*HPE-1:0] a_push, b_push;
  assign in_ready = (state == FEED) && (rem != '0);
  assign xfer     = in_valid && in_ready;
  assign flush    = state == CLEAR;
  assign a_push   = xfer ? a_vec : '0;
  assign b_push   = xfer ? b_vec : '0;
  // tile FSM: clear the array, count K transfers, wait out the drain, hold the result
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state     <= IDLE;
      rem       <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      sa_rst_n  <= 1'b0;
    end else begin
      sa_rst_n <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state    <= CLEAR;
          rem      <= k_len;
          busy     <= 1'b1;
          sa_rst_n <= 1'b0;
        end
        CLEAR: begin
          state <= (rem == '0) ? DRAIN : FEED;
          dcnt  <= DW'(D - 1);
        end
        FEED: if (xfer) begin
          rem <= rem - KW'(1);
          if (rem == KW'(1)) state <= DRAIN;
        end
        DRAIN: if (dcnt == '0) begin
          state     <= RESULT;
          res_valid <= 1'b1;
        end else dcnt <= dcnt - DW'(1);
        RESULT: if (res_ready) begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  for (genvar z = 0; z < HPE; z++) begin : g_lane
    sa_skew_line #(.WIDTH(WIDTH), .DEPTH(z + 1)) u_a (
      .CLK(CLK), .RST(RST), .flush(flush),
      .d(a_push[lane_lo(z, WIDTH) +: WIDTH]), .q(AA[lane_lo(z, WIDTH) +: WIDTH]));
    sa_skew_line #(.WIDTH(WIDTH), .DEPTH(z + 1)) u_b (
      .CLK(CLK), .RST(RST), .flush(flush),
      .d(b_push[lane_lo(z, WIDTH) +: WIDTH]), .q(BB[lane_lo(z, WIDTH) +: WIDTH]));
  end
`ifdef SA_SEQ_PERF_EN
  // CLEAR..RESULT cycles and FEED bubbles of the latest tile, held while idle
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == CLEAR) begin
      perf_cycles <= 32'd1;
      perf_stalls <= '0;
    end else if (state != IDLE) begin
      perf_cycles <= perf_cycles + 32'd1;
      perf_stalls <= perf_stalls + 32'(state == FEED && !xfer);
    end
`endif
endmodule

// File: tb/tb_sa_os_sequencer.sv
// tb_sa_os_sequencer: scoreboard bench for the tile sequencer driving a behavioural 4x4 array
`timescale 1ns/1ps
module tb_sa_os_sequencer;
  localparam int N = 4, W = 8, D = 7;
  logic CLK = 0, RST = 0, start = 0, in_valid = 0, res_ready = 0;
  logic [15:0] k_len = '0;
  logic [N*W-1:0] a_vec = '0, b_vec = '0;
  logic in_ready, sa_rst_n, busy, res_valid;
  logic [N*W-1:0] AA, BB;
`ifdef SA_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif
  int cyc = 0, checks = 0, errors = 0, cur_c = 0;
  logic [N*W-1:0] a_list [8], b_list [8];
  logic [N*W-1:0] a_hist [int], b_hist [int];
  logic [255:0] exp_y [$];
  int exp_cyc [$];
  logic [255:0] cur_y = '0, y_bus;
  logic rv_q = 0;
  logic [W-1:0] ah [N][N], bv [N][N];
  logic [15:0] acc [N][N];

  sa_os_sequencer #(.HPE(N), .VPE(N), .WIDTH(W), .KW(16), .PE_LAT(1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec), .AA(AA), .BB(BB),
    .sa_rst_n(sa_rst_n), .busy(busy), .res_valid(res_valid),
`ifdef SA_SEQ_PERF_EN
    .res_ready(res_ready), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`else
    .res_ready(res_ready)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [W-1:0] pa(input int i, input int j);
    return j == 0 ? AA[i*W +: W] : ah[i][j-1];
  endfunction
  function automatic logic [W-1:0] pb(input int i, input int j);
    return i == 0 ? BB[j*W +: W] : bv[i-1][j];
  endfunction

  // behavioural array: A moves along rows, B down columns, each PE accumulates a*b
  always @(posedge CLK)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!sa_rst_n) begin
          ah[i][j] <= '0; bv[i][j] <= '0; acc[i][j] <= '0;
        end else begin
          ah[i][j] <= pa(i, j); bv[i][j] <= pb(i, j);
          acc[i][j] <= acc[i][j] + 16'(pa(i, j)) * 16'(pb(i, j));
        end

  always_comb begin
    y_bus = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) y_bus[(i*N+j)*16 +: 16] = acc[i][j];
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // monitor: skew contents every cycle, scoreboard pop on each new result
  always @(negedge CLK) begin
    logic [N*W-1:0] ea, eb;
    if (!RST) begin a_hist.delete(); b_hist.delete(); end
    ea = '0; eb = '0;
    for (int z = 0; z < N; z++) begin
      if (a_hist.exists(cyc - 1 - z)) ea[z*W +: W] = a_hist[cyc-1-z][z*W +: W];
      if (b_hist.exists(cyc - 1 - z)) eb[z*W +: W] = b_hist[cyc-1-z][z*W +: W];
    end
    chk("aa_skew", AA, ea);
    chk("bb_skew", BB, eb);
    if (res_valid) begin
      if (!rv_q) begin
        if (exp_y.size() == 0) begin
          checks++; errors++; cur_y = '1;
          $display("FAIL res_valid_unexpected at cycle %0d: got 1 expected 0", cyc);
        end else begin
          cur_y = exp_y.pop_front();
          cur_c = exp_cyc.pop_front();
          chk("res_cycle", cyc, cur_c);
        end
      end
      chk("y_result", y_bus, cur_y);
    end
    rv_q = res_valid;
  end

  task automatic start_tile(input int k, input int nstall, input bit push);
    int yi [N][N];
    logic [255:0] y = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        yi[i][j] = 0;
        for (int n = 0; n < k; n++) yi[i][j] += int'(a_list[n][i*W +: W]) * int'(b_list[n][j*W +: W]);
        y[(i*N+j)*16 +: 16] = 16'(yi[i][j]);
      end
    @(posedge CLK); #1;
    start = 1; k_len = 16'(k);
    if (push) begin exp_y.push_back(y); exp_cyc.push_back(cyc + k + 2 + D + nstall); end
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic feed(input int n, input int stall_at, input int nstall);
    int sent = 0, s = 0, guard = 0;
    @(posedge CLK); #1;
    while (sent < n && guard < 50) begin
      guard++;
      if (sent == stall_at && s < nstall) begin in_valid = 0; s++; end
      else begin in_valid = 1; a_vec = a_list[sent]; b_vec = b_list[sent]; end
      if (in_valid && in_ready) begin a_hist[cyc] = a_vec; b_hist[cyc] = b_vec; sent++; end
      @(posedge CLK); #1;
    end
    in_valid = 0; a_vec = '0; b_vec = '0;
    chk("feed_count", sent, n);
  endtask

  task automatic finish_tile(input int hold, input bit poke);
    int g = 0;
    while (!res_valid && g < 60) begin @(posedge CLK); #1; g++; end
    chk("res_valid_seen", res_valid, 1);
    start = poke;
    repeat (hold) begin @(posedge CLK); #1; end
    res_ready = 1;
    @(posedge CLK); #1;
    res_ready = 0; start = 0;
    chk("res_valid_drop", res_valid, 0);
    @(posedge CLK); #1;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #3;
    chk("rst_sa_rst_n", sa_rst_n, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1;
    chk("idle_sa_rst_n", sa_rst_n, 1);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    for (int n = 0; n < 4; n++) begin a_list[n] = {4{8'd1}}; b_list[n] = {4{8'd1}}; end
    start_tile(4, 0, 1);
    chk("clear_sa_rst_n", sa_rst_n, 0);
    chk("clear_busy", busy, 1);
    feed(4, -1, 0);
    finish_tile(0, 0);
    a_list[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    b_list[0] = {8'd5, 8'd6, 8'd7, 8'd8};
    start_tile(1, 0, 1);
    feed(1, -1, 0);
    finish_tile(1, 0);
    for (int n = 0; n < 3; n++) begin a_list[n] = {8'd2, 8'd1, 8'd3, 8'd2}; b_list[n] = {4{8'd3}}; end
    start_tile(3, 2, 1);
    feed(3, 1, 2);
    finish_tile(0, 0);
`ifdef SA_SEQ_PERF_EN
    chk("perf_stalls", perf_stalls, 2);
    chk("perf_cycles", perf_cycles, 14);
`endif
    start_tile(0, 0, 1);
    feed(0, -1, 0);
    finish_tile(5, 1);
    for (int n = 0; n < 4; n++) begin a_list[n] = {4{8'd1}}; b_list[n] = {4{8'd2}}; end
    start_tile(4, 0, 0);
    feed(2, -1, 0);
    RST = 0; #1;
    chk("abort_sa_rst_n", sa_rst_n, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1;
    repeat (20) @(posedge CLK);
    #1;
    chk("abort_no_result", res_valid, 0);
    a_list[0] = {4{8'd3}}; b_list[0] = {4{8'd3}};
    start_tile(1, 0, 1);
    feed(1, -1, 0);
    finish_tile(0, 0);
    repeat (3) @(posedge CLK);
    chk("scoreboard_empty", exp_y.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
